// File: rtl/npu_accum_requant_if.sv
// Handshake and configuration bundle for the accumulate/requantise stage.
// The slave side is the stage; the master side drives partials and config and consumes int8 results.
interface npu_accum_requant_if;
   logic        start;
   logic [7:0]  tile_count;
   logic [31:0] bias;
   logic [15:0] scale_mult;
   logic [4:0]  scale_shift;
   logic        relu_en;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        err_drop;
   logic        sat_flag;

   modport master (
      output start, tile_count, bias, scale_mult, scale_shift, relu_en,
      output in_valid, in_data, out_ready,
      input  in_ready, out_data, out_valid, busy, err_drop, sat_flag
   );

   modport slave (
      input  start, tile_count, bias, scale_mult, scale_shift, relu_en,
      input  in_valid, in_data, out_ready,
      output in_ready, out_data, out_valid, busy, err_drop, sat_flag
   );
endinterface

// File: rtl/npu_accum_requant.sv
// Accumulates int32 partials into one neuron, adds bias, requantises to int8 and queues results.
// Result lands in the FIFO 3 edges after the last partial; a full FIFO holds the neuron in WAIT.
module npu_accum_requant #(
   parameter int FIFO_DEPTH = 4,
   parameter int ACC_W      = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   npu_accum_requant_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

   typedef enum logic [2:0] {IDLE, ACCUM, WAIT, MULT, ROUND, PUSH} state_t;

   typedef struct packed {
      logic [7:0]  tile_count;
      logic [15:0] scale_mult;
      logic [4:0]  scale_shift;
      logic        relu_en;
   } cfg_t;

   state_t                  state, state_nxt;
   cfg_t                    cfg;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              count;
   logic signed [47:0]      product;
   logic signed [47:0]      rnd;
   logic                    err_drop_q;
   logic                    sat_flag_q;

   logic [7:0]              mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [OCC_W-1:0]        occ;

   logic                    accept, last_tile, space, push, pop;
   logic signed [31:0]      acc_clamped;
   logic                    clamp_hit;
   logic signed [47:0]      clamped_ext, mult_ext, product_nxt, half, rnd_nxt, relu_val;
   logic [7:0]              push_dat;
   logic                    clip;

   assign accept    = (state == ACCUM) && bus.in_valid;
   assign last_tile = accept && ((count + 8'd1) == cfg.tile_count);
   assign space     = occ < OCC_W'(FIFO_DEPTH);
   // Each stage's result is registered on the edge that enters that stage.
   assign push      = (state == ROUND);
   assign pop       = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ACCUM;
         ACCUM:   if (last_tile) state_nxt = WAIT;
         WAIT:    if (space)     state_nxt = MULT;
         MULT:    state_nxt = ROUND;
         ROUND:   state_nxt = PUSH;
         PUSH:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state == ACCUM);
      bus.busy     = (state != IDLE);
   end

   always_comb begin
      acc_clamped = acc[31:0];
      clamp_hit   = 1'b0;
      if (acc > ACC_MAX) begin
         acc_clamped = 32'h7FFF_FFFF;
         clamp_hit   = 1'b1;
      end else if (acc < ACC_MIN) begin
         acc_clamped = 32'h8000_0000;
         clamp_hit   = 1'b1;
      end
      clamped_ext = {{16{acc_clamped[31]}}, acc_clamped};
      mult_ext    = {{32{cfg.scale_mult[15]}}, cfg.scale_mult};
      product_nxt = clamped_ext * mult_ext;

      // Adding half an LSB before the arithmetic shift rounds ties toward +infinity.
      half    = 48'sd1 <<< (cfg.scale_shift - 5'd1);
      rnd_nxt = (cfg.scale_shift == 5'd0) ? product : ((product + half) >>> cfg.scale_shift);

      relu_val = (cfg.relu_en && (rnd < 48'sd0)) ? 48'sd0 : rnd;
      push_dat = relu_val[7:0];
      clip     = 1'b0;
      if (relu_val > 48'sd127) begin
         push_dat = 8'h7F;
         clip     = 1'b1;
      end else if (relu_val < -48'sd128) begin
         push_dat = 8'h80;
         clip     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg        <= '0;
         acc        <= '0;
         count      <= '0;
         product    <= '0;
         rnd        <= '0;
         err_drop_q <= 1'b0;
         sat_flag_q <= 1'b0;
      end else begin
         if (state == IDLE && bus.start) begin
            cfg.tile_count  <= (bus.tile_count == 8'd0) ? 8'd1 : bus.tile_count;
            cfg.scale_mult  <= bus.scale_mult;
            cfg.scale_shift <= bus.scale_shift;
            cfg.relu_en     <= bus.relu_en;
            acc             <= {{(ACC_W-32){bus.bias[31]}}, bus.bias};
            count           <= 8'd0;
         end
         if (accept) begin
            acc   <= acc + {{(ACC_W-32){bus.in_data[31]}}, bus.in_data};
            count <= count + 8'd1;
         end
         if (bus.in_valid && !bus.in_ready) err_drop_q <= 1'b1;
         if (state == WAIT && space) begin
            product <= product_nxt;
            if (clamp_hit) sat_flag_q <= 1'b1;
         end
         if (state == MULT) rnd <= rnd_nxt;
         if (push && clip) sat_flag_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign bus.out_valid = (occ != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'd0;
   assign bus.err_drop  = err_drop_q;
   assign bus.sat_flag  = sat_flag_q;
endmodule
